imem_ctrl: RTL

- Instruction-memory controller on the memory side of the instruction cache in the fetch stage.
- Accepts the icache's miss strobe/address and drives the word-addressed instruction ROM.
- Models a fixed multi-cycle memory latency, then returns the fetched word with a one-cycle ready pulse.
- Replaces the free-running ready counter, so ready is tied to an actual request and flush aborts are handled.

---
 rtl/imem_ctrl_pkg.sv | 13 +
 rtl/lat_counter.sv | 27 ++
 rtl/imem_ctrl.sv | 99 +++++++++
 3 files changed

// File: rtl/imem_ctrl_pkg.sv
// Shared definitions for the instruction- and data-memory controllers:
// controller state encoding and the default memory latency.
package imem_ctrl_pkg;

  typedef enum logic [1:0] {
    IMC_IDLE  = 2'd0,
    IMC_WAIT  = 2'd1,
    IMC_READY = 2'd2
  } imc_state_e;

  localparam int IMC_LATENCY = 5;

endpackage

// File: rtl/lat_counter.sv
// Loadable down-counter with a zero flag; saturates at zero so it never wraps
// while a caller keeps decrement asserted.
module lat_counter #(
  parameter int W = 4
) (
  input  logic         clock,
  input  logic         resetn,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic [W-1:0] count,
  output logic         zero
);

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (dec && (count != '0)) begin
      count <= count - W'(1);
    end
  end

  assign zero = (count == '0);

endmodule

// File: rtl/imem_ctrl.sv
// Instruction-memory controller: latches an icache miss, waits a fixed latency,
// then returns the ROM word with a one-cycle m_ready pulse. m_abort cancels a waiting request.
module imem_ctrl
  import imem_ctrl_pkg::*;
#(
  parameter int LATENCY = IMC_LATENCY,
  parameter int ROM_AW  = 6,
  parameter int CNT_W   = 4
) (
  input  logic              clock,
  input  logic              resetn,
  input  logic              m_strobe,
  input  logic [31:0]       m_a,
  input  logic              m_abort,
  output logic [ROM_AW-1:0] rom_addr,
  input  logic [31:0]       rom_data,
  output logic [31:0]       m_dout,
  output logic              m_ready,
  output logic              m_err,
  output logic              busy,
  output logic [15:0]       req_count,
  output imc_state_e        state
);

  localparam logic [CNT_W-1:0] LOAD_VAL = CNT_W'(LATENCY - 1);

  // Handshake: m_strobe is a level request held until m_ready; it is sampled
  // only in IDLE with m_abort low. m_ready is a single-cycle pulse and m_dout
  // is valid only while it is high.

  logic [31:0]      addr_q;
  logic [CNT_W-1:0] cnt;
  logic             cnt_zero;
  logic             accept;
  logic             oor;
  logic             unused_ok;

  assign accept = (state == IMC_IDLE) && m_strobe && !m_abort;
  assign oor    = (addr_q[31:ROM_AW+2] != '0);

  // Loaded with LATENCY-1 on acceptance; the edge that sees zero raises m_ready,
  // giving exactly LATENCY edges from acceptance to the pulse.
  lat_counter #(
    .W (CNT_W)
  ) u_lat (
    .clock    (clock),
    .resetn   (resetn),
    .load     (accept),
    .load_val (LOAD_VAL),
    .dec      (state == IMC_WAIT),
    .count    (cnt),
    .zero     (cnt_zero)
  );

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state     <= IMC_IDLE;
      addr_q    <= '0;
      m_dout    <= '0;
      m_ready   <= 1'b0;
      m_err     <= 1'b0;
      req_count <= '0;
    end else begin
      case (state)
        IMC_IDLE: begin
          if (accept) begin
            addr_q <= m_a;
            state  <= IMC_WAIT;
          end
        end
        IMC_WAIT: begin
          if (m_abort) begin
            state <= IMC_IDLE;
          end else if (cnt_zero) begin
            m_dout  <= oor ? 32'd0 : rom_data;
            m_ready <= 1'b1;
            m_err   <= oor;
            state   <= IMC_READY;
          end
        end
        IMC_READY: begin
          // Data already went out; an abort here cannot retract it.
          m_ready   <= 1'b0;
          m_err     <= 1'b0;
          req_count <= req_count + 16'd1;
          state     <= IMC_IDLE;
        end
        default: begin
          state <= IMC_IDLE;
        end
      endcase
    end
  end

  assign rom_addr  = addr_q[ROM_AW+1:2];
  assign busy      = (state != IMC_IDLE);
  assign unused_ok = ^{addr_q[1:0], cnt};

endmodule
